// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader.
//   state_e        : loader FSM states (idle, accept a word, write its bytes, done pulse)
//   BYTES_PER_WORD : bytes written per accepted instruction word
//   WORD_W         : instruction word width
//   MAX_WORDS      : largest load length; longer requests are clamped to this
package instr_mem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned MAX_WORDS      = 64;
  localparam int unsigned COUNT_W        = 7;   // holds 0..MAX_WORDS
  localparam int unsigned IDX_W          = 2;   // byte index within a word

  typedef enum logic [1:0] {
    StIdle,
    StAccept,
    StWrite,
    StDone
  } state_e;

  // Requests beyond MAX_WORDS are treated as exactly MAX_WORDS.
  function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] wc);
    logic [COUNT_W-1:0] max_wc;
    max_wc = COUNT_W'(MAX_WORDS);
    return (wc > max_wc) ? max_wc : wc;
  endfunction

  // Big-endian byte select: index 0 is the most significant byte.
  function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w,
                                           input logic [IDX_W-1:0]  idx);
    logic [7:0] b;
    b = '0;
    unique case (idx)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      2'd3: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: accepts 32-bit instruction words over a valid/ready
// stream and writes each one into a byte-wide memory port as four big-endian
// bytes at consecutive (wrapping) addresses.
//
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   start       one-cycle load request, honoured only when idle
//   base_addr   byte address of the first byte written (latched on start)
//   word_count  number of words to load, clamped to 64 (latched on start)
//   in_valid    in_data carries a valid word
//   in_data     instruction word
//   in_ready    loader will take in_data this cycle
//   mem_we      byte write enable
//   mem_addr    byte write address
//   mem_wdata   byte write data
//   busy        loader is not idle
//   done        one-cycle pulse at the end of a load
//
// Every output is a flop whose next value is decoded from the next-state
// signals, so there is no combinational input-to-output path.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [COUNT_W-1:0] word_count,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [7:0]         mem_wdata,
  output logic               busy,
  output logic               done
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(BYTES_PER_WORD - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COUNT_W-1:0]  remain_q, remain_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    data_d   = data_q;
    idx_d    = idx_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (word_count == '0) begin
            state_d = StDone;
          end else begin
            addr_d   = base_addr;
            remain_d = clamp_count(word_count);
            state_d  = StAccept;
          end
        end
      end
      StAccept: begin
        if (in_valid && in_ready_q) begin
          data_d  = in_data;
          idx_d   = '0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        // Address advances after every byte and wraps naturally at 2^ADDR_W.
        addr_d = addr_q + 1'b1;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          remain_d = remain_q - 1'b1;
          state_d  = (remain_q == COUNT_W'(1)) ? StDone : StAccept;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs for the coming cycle, decoded from the next state.
    in_ready_d  = (state_d == StAccept);
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    mem_we_d    = (state_d == StWrite);
    mem_addr_d  = mem_we_d ? addr_d : '0;
    mem_wdata_d = mem_we_d ? word_byte(data_d, idx_d) : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remain_q    <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the byte-address width of the instruction memory write port.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: clock input (1), rising-edge active; reset_n input (1), asynchronous, active-low.
REQ-003 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-004 base_addr  input  ADDR_W  byte address of the first byte written; latched on an accepted start.
REQ-005 word_count  input  7  number of 32-bit words to load, 0..64; latched on an accepted start.
REQ-006 in_valid  input  1  in_data holds a valid instruction word.
REQ-007 in_data  input  32  instruction word to store.
REQ-008 in_ready  output  1  loader accepts in_data this cycle.
REQ-009 mem_we  output  1  byte write enable to instruction memory.
REQ-010 mem_addr  output  ADDR_W  byte address of the current write.
REQ-011 mem_wdata  output  8  byte written.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse when the load completes.

Function
REQ-014 The FSM SHALL have four states: IDLE, ACCEPT, WRITE, DONE.
REQ-015 In IDLE with start=1: if word_count=0, go to DONE; otherwise latch base_addr into the address counter and word_count into the remaining counter, then go to ACCEPT.
REQ-016 In ACCEPT, in_ready SHALL be 1. A handshake is in_valid=1 and in_ready=1 in the same cycle. On a handshake, latch in_data, clear the byte index to 0, and go to WRITE. Without a handshake, stay in ACCEPT indefinitely.
REQ-017 WRITE SHALL last exactly 4 cycles, with mem_we=1 in each. Bytes are written big-endian: index 0 writes in_data[31:24], index 1 writes [23:16], index 2 writes [15:8], index 3 writes [7:0].
REQ-018 mem_addr SHALL increment by 1 after each byte and wrap modulo 2^ADDR_W (255 -> 0 for ADDR_W=8).
REQ-019 After byte index 3, decrement the remaining counter. If it reaches 0, go to DONE; otherwise go to ACCEPT.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-021 All outputs SHALL be registered or decoded from registered state only; there is no combinational path from inputs to outputs.
REQ-022 in_ready SHALL be 0 in IDLE, WRITE and DONE.
REQ-023 mem_we, mem_addr and mem_wdata SHALL be 0 outside WRITE.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 word_count values above 64 SHALL be clamped to 64.
REQ-026 Sustained throughput SHALL be one word per 5 cycles when in_valid is held high.
REQ-027 Latency from the accepting handshake edge to the first mem_we=1 cycle SHALL be 1 cycle.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE and clear all counters and the data register. It SHALL drive in_ready, mem_we, mem_addr, mem_wdata, busy and done to 0.
REQ-029 A reset asserted mid-load SHALL abort the load, with no further writes and no done pulse. Bytes already written are left as written.
REQ-030 After reset_n deasserts, the first start SHALL be honoured on the first rising clock edge.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, ACCEPT, WRITE, DONE), BYTES_PER_WORD=4, WORD_W=32, and MAX_WORDS=64.
REQ-032 The block SHALL be a single module with no sub-modules; the byte serialiser is the WRITE state itself.

Verification
REQ-033 Single word: base_addr=0x00, word_count=1, in_data=0x8C220004 held valid -> writes (0x00,0x8C), (0x01,0x22), (0x02,0x00), (0x03,0x04) on 4 consecutive cycles, followed by one done pulse.
REQ-034 Back-to-back: base_addr=0x10, word_count=3, in_valid held high -> 12 writes to 0x10..0x1B, in_ready high exactly 3 cycles, done 15 cycles after the first ACCEPT cycle.
REQ-035 Wrap: base_addr=0xFE, word_count=1, in_data=0x11223344 -> writes 0xFE=0x11, 0xFF=0x22, 0x00=0x33, 0x01=0x44.
REQ-036 Stall and ignored start: in_valid withheld 7 cycles in ACCEPT -> no writes, in_ready stays 1; start pulsed mid-WRITE -> no effect on addresses or count.
REQ-037 Reset mid-load: reset_n asserted during byte index 2 of word 2 of 4 -> all outputs 0 the same cycle, no done pulse, IDLE after release; a fresh start with base_addr=0x40 loads correctly.
REQ-038 Edge counts: word_count=0 -> done one cycle after start, zero writes. word_count=100 -> exactly 64 words (256 writes).
